// File: rtl/cpu_program_loader.sv
// cpu_program_loader: boot-time loader feeding the pipelined RISC-V cpu.
// Parses segment headers from a 32-bit valid/ready stream, writes payload
// into instruction memory (32-bit words) or data memory (64-bit words),
// then enables the cpu and counts its execution cycles.
// Optional feature: define CPU_LOADER_CHECKSUM_EN to require one XOR
// checksum beat after every segment.
module cpu_program_loader #(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error,
    output logic [31:0] run_cycles
);

    typedef enum logic [2:0] {
        HDR,
        IMEM,
        DMEM_LO,
        DMEM_HI,
`ifdef CPU_LOADER_CHECKSUM_EN
        CHK,
`endif
        RUN,
        ERROR
    } state_t;

    state_t      state_q, state_d, seg_done;
    logic        tgt_q, last_q, seg_seen_q;
    logic [13:0] base_q;
    logic [15:0] cnt_q, idx_q;
    logic [31:0] lo_q;
`ifdef CPU_LOADER_CHECKSUM_EN
    logic [31:0] csum_q;
`endif
    logic        accept, hdr_load, imem_wr, dmem_wr, lo_load;
    logic [16:0] hdr_span, hdr_limit;
    logic        word_last;
    logic [63:0] word_idx;

    // Next-state decode and per-beat control strobes
    always_comb begin
        state_d   = state_q;
        hdr_load  = 1'b0;
        imem_wr   = 1'b0;
        dmem_wr   = 1'b0;
        lo_load   = 1'b0;
        accept    = s_valid && s_ready;
        hdr_span  = 17'(s_data[29:16]) + 17'(s_data[15:0]);
        hdr_limit = s_data[31] ? 17'(DMEM_WORDS) : 17'(IMEM_WORDS);
        word_last = (17'(idx_q) + 17'd1) == 17'(cnt_q);
        word_idx  = 64'(base_q) + 64'(idx_q);
`ifdef CPU_LOADER_CHECKSUM_EN
        seg_done  = CHK;
`else
        seg_done  = last_q ? RUN : HDR;
`endif
        case (state_q)
            HDR: begin
                if (accept) begin
                    hdr_load = 1'b1;
                    if (hdr_span > hdr_limit) begin
                        state_d = ERROR;
                    end else if (s_data[15:0] == 16'd0) begin
`ifdef CPU_LOADER_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d = s_data[30] ? RUN : HDR;
`endif
                    end else begin
                        state_d = s_data[31] ? DMEM_LO : IMEM;
                    end
                end
            end
            IMEM: begin
                if (accept) begin
                    imem_wr = 1'b1;
                    if (word_last) state_d = seg_done;
                end
            end
            DMEM_LO: begin
                if (accept) begin
                    lo_load = 1'b1;
                    state_d = DMEM_HI;
                end
            end
            DMEM_HI: begin
                if (accept) begin
                    dmem_wr = 1'b1;
                    state_d = word_last ? seg_done : DMEM_LO;
                end
            end
`ifdef CPU_LOADER_CHECKSUM_EN
            CHK: begin
                if (accept) begin
                    state_d = (s_data == csum_q) ? (last_q ? RUN : HDR) : ERROR;
                end
            end
`endif
            RUN:     state_d = RUN;
            ERROR:   state_d = ERROR;
            default: state_d = HDR;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (srst) state_q <= HDR;
        else      state_q <= state_d;
    end

    // Segment bookkeeping, registered memory ports and status outputs
    always_ff @(posedge clk) begin
        if (srst) begin
            tgt_q       <= 1'b0;
            last_q      <= 1'b0;
            seg_seen_q  <= 1'b0;
            base_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            lo_q        <= '0;
`ifdef CPU_LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
            s_ready     <= 1'b1;
            addr_ext    <= '0;
            wen_ext     <= 1'b0;
            wdata_ext   <= '0;
            addr_ext_2  <= '0;
            wen_ext_2   <= 1'b0;
            wdata_ext_2 <= '0;
            cpu_enable  <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            run_cycles  <= '0;
        end else begin
            wen_ext   <= imem_wr;
            wen_ext_2 <= dmem_wr;
            if (hdr_load) begin
                tgt_q      <= s_data[31];
                last_q     <= s_data[30];
                base_q     <= s_data[29:16];
                cnt_q      <= s_data[15:0];
                idx_q      <= '0;
                seg_seen_q <= 1'b1;
            end
            if (imem_wr) begin
                addr_ext  <= {word_idx[61:0], 2'b00};
                wdata_ext <= s_data;
                idx_q     <= idx_q + 16'd1;
            end
            if (lo_load) lo_q <= s_data;
            if (dmem_wr) begin
                addr_ext_2  <= {word_idx[60:0], 3'b000};
                wdata_ext_2 <= {s_data, lo_q};
                idx_q       <= idx_q + 16'd1;
            end
`ifdef CPU_LOADER_CHECKSUM_EN
            if (hdr_load)                          csum_q <= s_data;
            else if (imem_wr || lo_load || dmem_wr) csum_q <= csum_q ^ s_data;
`endif
            // Status flags are decoded from the next state so they line up with it
            s_ready    <= (state_d != RUN) && (state_d != ERROR);
            busy       <= (state_d != RUN) && (state_d != ERROR) &&
                          ((state_d != HDR) || seg_seen_q || hdr_load);
            cpu_enable <= (state_d == RUN);
            error      <= error || (state_d == ERROR);
            if (state_d == RUN) begin
                if (state_q != RUN)        run_cycles <= 32'd1;
                else if (run_cycles != '1) run_cycles <= run_cycles + 32'd1;
            end
        end
    end

    logic unused_tgt;
    assign unused_tgt = tgt_q;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Self-checking bench for cpu_program_loader: directed segments plus random
// multi-segment streams with throttled valid, checked against a stream parser.
// Honours CPU_LOADER_CHECKSUM_EN the same way as the design.
module tb_cpu_program_loader;

    localparam int IMEM = 512;
    localparam int DMEM = 1024;

    logic        clk, srst, s_valid, s_ready;
    logic [31:0] s_data, wdata_ext, run_cycles;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, wen_ext_2, cpu_enable, busy, error;

    cpu_program_loader #(.IMEM_WORDS(IMEM), .DMEM_WORDS(DMEM)) dut (
        .clk(clk), .srst(srst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .wdata_ext_2(wdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .error(error), .run_cycles(run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  stream_q[$];
    logic [95:0]  obs_i[$], exp_i[$];
    logic [127:0] obs_d[$], exp_d[$];
    int unsigned  n_tests = 0, n_fail = 0;
    int           negcnt = 0, last_acc = -100, en_neg = 0, overlap = 0;
    bit           en_seen = 0, exp_run, exp_err, exp_seen;
    logic [31:0]  en_rc, cs_build;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Passive monitor on the falling edge
    always @(negedge clk) begin
        negcnt++;
        if (wen_ext)   obs_i.push_back({addr_ext, wdata_ext});
        if (wen_ext_2) obs_d.push_back({addr_ext_2, wdata_ext_2});
        if (wen_ext && wen_ext_2) overlap++;
        if (s_valid && s_ready && !srst) last_acc = negcnt;
        if (cpu_enable && !en_seen) begin
            en_seen = 1;
            en_neg  = negcnt;
            en_rc   = run_cycles;
        end
    end

    task automatic add_hdr(input logic [31:0] h);
        stream_q.push_back(h);
        cs_build = h;
    endtask

    task automatic add_word(input logic [31:0] w);
        stream_q.push_back(w);
        cs_build ^= w;
    endtask

    task automatic end_seg();
`ifdef CPU_LOADER_CHECKSUM_EN
        stream_q.push_back(cs_build);
`endif
    endtask

    // Reference: walk the stream word by word using the header rules
    task automatic model_run();
        int p, b, n;
        logic t, l;
        logic [31:0] h, cs, lo;
        exp_i.delete(); exp_d.delete();
        exp_run = 0; exp_err = 0; exp_seen = 0; p = 0;
        while (p < stream_q.size()) begin
            h = stream_q[p]; p++; exp_seen = 1;
            t = h[31]; l = h[30]; b = int'(h[29:16]); n = int'(h[15:0]); cs = h;
            if (b + n > (t ? DMEM : IMEM)) begin exp_err = 1; return; end
            for (int k = 0; k < n; k++) begin
                if (!t) begin
                    if (p >= stream_q.size()) return;
                    cs ^= stream_q[p];
                    exp_i.push_back({64'((b + k) * 4), stream_q[p]});
                    p++;
                end else begin
                    if (p + 1 >= stream_q.size()) return;
                    lo = stream_q[p];
                    cs ^= lo ^ stream_q[p+1];
                    exp_d.push_back({64'((b + k) * 8), stream_q[p+1], lo});
                    p += 2;
                end
            end
`ifdef CPU_LOADER_CHECKSUM_EN
            if (p >= stream_q.size()) return;
            if (stream_q[p] != cs) begin exp_err = 1; return; end
            p++;
`endif
            if (l) begin exp_run = 1; return; end
        end
    endtask

    task automatic drive_stream(input int gap_pct, input int max_words);
        int p = 0;
        int tries = 0;
        while (p < stream_q.size() && p < max_words && tries < 5000) begin
            @(posedge clk); #1;
            tries++;
            if ($urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                s_data  = $urandom;
            end else begin
                s_valid = 1'b1;
                s_data  = stream_q[p];
            end
            @(negedge clk);
            if (!s_ready) break;
            if (s_valid) p++;
        end
        if (tries >= 5000) check_eq("drive_timeout", tries, 0);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_eq({pfx, "_s_ready"},    s_ready, 1);
        check_eq({pfx, "_wen"},        wen_ext, 0);
        check_eq({pfx, "_wen2"},       wen_ext_2, 0);
        check_eq({pfx, "_addr"},       addr_ext, 0);
        check_eq({pfx, "_addr2"},      addr_ext_2, 0);
        check_eq({pfx, "_wdata"},      wdata_ext, 0);
        check_eq({pfx, "_wdata2"},     wdata_ext_2, 0);
        check_eq({pfx, "_cpu_enable"}, cpu_enable, 0);
        check_eq({pfx, "_busy"},       busy, 0);
        check_eq({pfx, "_error"},      error, 0);
        check_eq({pfx, "_run_cycles"}, run_cycles, 0);
    endtask

    task automatic start_case();
        @(posedge clk); #1;
        srst = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        srst = 1'b0;
        obs_i.delete(); obs_d.delete();
        en_seen = 0; last_acc = -100; overlap = 0;
        stream_q.delete();
    endtask

    task automatic cmp_writes(input string tag);
        model_run();
        check_eq({tag, "_imem_cnt"}, obs_i.size(), exp_i.size());
        for (int i = 0; i < obs_i.size() && i < exp_i.size(); i++)
            check_eq({tag, "_imem_wr"}, obs_i[i], exp_i[i]);
        check_eq({tag, "_dmem_cnt"}, obs_d.size(), exp_d.size());
        for (int i = 0; i < obs_d.size() && i < exp_d.size(); i++)
            check_eq({tag, "_dmem_wr"}, obs_d[i], exp_d[i]);
        check_eq({tag, "_overlap"}, overlap, 0);
    endtask

    task automatic finish_case(input string tag);
        repeat (12) @(posedge clk);
        @(negedge clk); #1;
        cmp_writes(tag);
        check_eq({tag, "_error"},      error, exp_err);
        check_eq({tag, "_cpu_enable"}, cpu_enable, exp_run);
        check_eq({tag, "_s_ready"},    s_ready, !(exp_run || exp_err));
        check_eq({tag, "_busy"},       busy, exp_seen && !exp_run && !exp_err);
        if (exp_run) begin
            check_eq({tag, "_en_latency"}, en_neg, last_acc + 1);
            check_eq({tag, "_rc_first"},   en_rc, 1);
            check_eq({tag, "_rc_now"},     run_cycles, negcnt - en_neg + 1);
        end
    endtask

    task automatic build_random();
        int nseg, depth, n, base;
        logic t;
        nseg = $urandom_range(1, 4);
        for (int s = 0; s < nseg; s++) begin
            t     = 1'($urandom_range(1));
            depth = t ? DMEM : IMEM;
            if ($urandom_range(7) == 0) begin
                n    = $urandom_range(1, 6);
                base = depth - n + $urandom_range(1, 3);
            end else begin
                n    = $urandom_range(0, 6);
                base = $urandom_range(0, depth - n);
            end
            add_hdr({t, 1'(s == nseg - 1), 14'(base), 16'(n)});
            for (int k = 0; k < n; k++) begin
                add_word($urandom);
                if (t) add_word($urandom);
            end
            end_seg();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        srst = 1'b1; s_valid = 1'b0; s_data = '0;
        repeat (2) @(posedge clk); #1;
        srst = 1'b0;
        @(negedge clk); #1;
        check_reset_vals("rst");

        // imem load of three instructions, last segment
        start_case();
        add_hdr(32'h4000_0003);
        add_word(32'h0000_0013); add_word(32'h0010_0093); add_word(32'h0020_8113);
        end_seg();
        drive_stream(0, 1000);
        finish_case("imem3");

        // dmem word then empty last imem segment
        start_case();
        add_hdr(32'h8002_0001); add_word(32'hDEAD_BEEF); add_word(32'h0123_4567); end_seg();
        add_hdr(32'h4000_0000); end_seg();
        drive_stream(0, 1000);
        finish_case("dmem1");
        check_eq("dmem1_spec_cnt", obs_d.size(), 1);
        if (obs_d.size() > 0) check_eq("dmem1_spec", obs_d[0], {64'h10, 64'h0123_4567_DEAD_BEEF});

        // range error at top of imem
        start_case();
        add_hdr(32'h01FF_0002); add_word(32'h1111_1111); add_word(32'h2222_2222); end_seg();
        drive_stream(0, 1000);
        finish_case("range");

        // 16-word imem segment with throttled valid
        start_case();
        add_hdr(32'h4000_0010);
        for (int k = 0; k < 16; k++) add_word($urandom);
        end_seg();
        drive_stream(40, 1000);
        finish_case("throttle");

        // reset after two of five payload beats; srst beats a concurrent header
        start_case();
        add_hdr(32'h4000_0005);
        for (int k = 0; k < 5; k++) add_word($urandom);
        end_seg();
        drive_stream(0, 3);
        srst = 1'b1; s_valid = 1'b1; s_data = 32'h4000_0001;
        @(posedge clk); #1;
        srst = 1'b0; s_valid = 1'b0;
        @(negedge clk); #1;
        check_reset_vals("midrst");
        while (stream_q.size() > 3) void'(stream_q.pop_back());
        cmp_writes("midrst");

        // fresh load after the mid-segment reset
        start_case();
        add_hdr(32'h4004_0002); add_word($urandom); add_word($urandom); end_seg();
        drive_stream(0, 1000);
        finish_case("fresh");

`ifdef CPU_LOADER_CHECKSUM_EN
        // corrupted checksum beat
        start_case();
        add_hdr(32'h4000_0003);
        add_word(32'h0000_0013); add_word(32'h0010_0093); add_word(32'h0020_8113);
        end_seg();
        stream_q[stream_q.size() - 1] ^= 32'h0000_0001;
        drive_stream(0, 1000);
        finish_case("badsum");
`endif

        for (int r = 0; r < 20; r++) begin
            start_case();
            build_random();
            drive_stream($urandom_range(0, 50), 1000);
            finish_case("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
